// File: rtl/viola_pkg.sv
// Shared definitions for the Haar cascade blocks: sequencer state encoding,
// feature word layout and rectangle beat type codes.
package viola_pkg;

  // Sequencer states, one per phase of issuing a single feature.
  typedef enum logic [2:0] {
    IDLE,
    FETCH0,
    FETCH1,
    SEND1,
    GUARD,
    WAIT,
    DONE
  } seq_state_t;

  // Each feature occupies two consecutive words: rect1 then rect2.
  localparam int FEAT_WORDS = 2;

  // Beat type codes presented to the rectangle parser.
  localparam logic RECT_TYPE_1 = 1'b0;
  localparam logic RECT_TYPE_2 = 1'b1;

endpackage

// File: rtl/haar_feature_sequencer.sv
// Haar feature sequencer: walks the features of one cascade stage, reads the
// two words of each feature from the feature memory and streams them to the
// rectangle parser as two back-to-back beats, then waits for the parser to
// finish before moving to the next feature.
module haar_feature_sequencer
  import viola_pkg::*;
#(
  parameter int FEAT_ADDR_WIDTH = 12,
  parameter int FEAT_CNT_WIDTH  = 8,
  parameter int GUARD_CYCLES    = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       start_i,
  input  logic [FEAT_ADDR_WIDTH-1:0] base_addr_i,
  input  logic [FEAT_CNT_WIDTH-1:0]  feat_num_i,
  input  logic                       abort_i,
  output logic [FEAT_ADDR_WIDTH-1:0] feat_addr_o,
  output logic                       feat_rd_o,
  input  logic [31:0]                feat_data_i,
  output logic                       rect_val_o,
  output logic                       type_rect_o,
  output logic [31:0]                rect_o,
  input  logic                       wait_i,
  output logic [FEAT_CNT_WIDTH-1:0]  feat_idx_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

  seq_state_t                 state_q, state_d;
  logic [FEAT_ADDR_WIDTH-1:0] base_q, base_d;
  logic [FEAT_CNT_WIDTH-1:0]  num_q, num_d;
  logic [FEAT_CNT_WIDTH-1:0]  idx_q, idx_d;
  logic [GW-1:0]              guard_q, guard_d;
  logic [FEAT_ADDR_WIDTH-1:0] fetch_addr;
  logic                       fetch_d;

  // Read data is handed straight to the parser; the beat valid/type
  // registers line up with the cycle the memory returns each word.
  assign rect_o     = feat_data_i;
  assign feat_idx_o = idx_q;

  // Next-state, index and guard-counter decisions for the stage walk.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    base_d  = base_q;
    num_d   = num_q;
    idx_d   = idx_q;
    guard_d = guard_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d  = base_addr_i;
          num_d   = feat_num_i;
          idx_d   = '0;
          state_d = (feat_num_i != '0) ? FETCH0 : DONE;
        end
      end
      FETCH0: state_d = FETCH1;
      FETCH1: state_d = SEND1;
      SEND1: begin
        guard_d = '0;
        state_d = GUARD;
      end
      GUARD: begin
        // The parser needs a few cycles before wait_i reflects the new
        // feature, so wait_i is not looked at until this window expires.
        if (guard_q == GUARD_LAST) state_d = WAIT;
        else                       guard_d = guard_q + 1'b1;
      end
      WAIT: begin
        if (!wait_i) begin
          if (idx_q == num_q - 1'b1) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = FETCH0;
          end
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort beats any other transition once a stage is under way.
    if (abort_i && (state_q != IDLE)) begin
      idx_d   = '0;
      state_d = IDLE;
    end
  end

  // Address of the word fetched in the upcoming state; wraps modulo 2^W.
  assign fetch_d    = (state_d == FETCH0) || (state_d == FETCH1);
  assign fetch_addr = base_d
                    + FEAT_ADDR_WIDTH'(idx_d) * FEAT_ADDR_WIDTH'(FEAT_WORDS)
                    + FEAT_ADDR_WIDTH'(state_d == FETCH1);

  // State and context registers plus outputs registered from the next state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      base_q      <= '0;
      num_q       <= '0;
      idx_q       <= '0;
      guard_q     <= '0;
      feat_rd_o   <= 1'b0;
      feat_addr_o <= '0;
      rect_val_o  <= 1'b0;
      type_rect_o <= RECT_TYPE_1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the
      // same pre-edge values, whatever order the statements are written in.
      state_q     <= state_d;
      base_q      <= base_d;
      num_q       <= num_d;
      idx_q       <= idx_d;
      guard_q     <= guard_d;
      feat_rd_o   <= fetch_d;
      feat_addr_o <= fetch_d ? fetch_addr : '0;
      rect_val_o  <= (state_d == FETCH1) || (state_d == SEND1);
      type_rect_o <= (state_d == SEND1) ? RECT_TYPE_2 : RECT_TYPE_1;
      busy_o      <= (state_d != IDLE) && (state_d != DONE);
      done_o      <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_haar_feature_sequencer.sv
// Self-checking bench for haar_feature_sequencer. A feature ROM and a parser
// model drive the DUT; a monitor logs reads, beats, done pulses and busy
// cycles, which each scenario compares against a timeline computed from the
// stage parameters and the parser wait durations.
`timescale 1ns/1ps
module tb_haar_feature_sequencer;

  localparam int AW = 12;
  localparam int CW = 8;
  localparam int G  = 2;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [CW-1:0] feat_num_i = '0;
  logic          abort_i = 1'b0;
  logic [AW-1:0] feat_addr_o;
  logic          feat_rd_o;
  logic [31:0]   feat_data_i = '0;
  logic          rect_val_o;
  logic          type_rect_o;
  logic [31:0]   rect_o;
  logic          wait_i = 1'b0;
  logic [CW-1:0] feat_idx_o;
  logic          busy_o;
  logic          done_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  haar_feature_sequencer #(
    .FEAT_ADDR_WIDTH(AW),
    .FEAT_CNT_WIDTH (CW),
    .GUARD_CYCLES   (G)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .feat_num_i (feat_num_i),
    .abort_i    (abort_i),
    .feat_addr_o(feat_addr_o),
    .feat_rd_o  (feat_rd_o),
    .feat_data_i(feat_data_i),
    .rect_val_o (rect_val_o),
    .type_rect_o(type_rect_o),
    .rect_o     (rect_o),
    .wait_i     (wait_i),
    .feat_idx_o (feat_idx_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Feature ROM contents are a fixed function of the address.
  function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
    return {4'hA, a, 4'h5, ~a};
  endfunction

  // One-cycle-latency feature memory; junk on the bus when not reading.
  always @(posedge clk_i) feat_data_i <= feat_rd_o ? rom_word(feat_addr_o) : $urandom;

  typedef struct {int cyc; logic [AW-1:0] addr;} rd_ev_t;
  typedef struct {int cyc; logic typ; logic [31:0] data; logic [CW-1:0] idx;} beat_ev_t;

  rd_ev_t   rd_q[$];
  beat_ev_t beat_q[$];
  int       done_q[$];
  int       busy_cnt = 0;
  int       busy_first = -1;
  int       h_q[$];

  // Monitor: log every observable event with its cycle number.
  always @(negedge clk_i) begin : mon
    rd_ev_t   r;
    beat_ev_t b;
    if (rst_n_i) begin
      if (feat_rd_o) begin
        r.cyc = cyc; r.addr = feat_addr_o;
        rd_q.push_back(r);
      end
      if (rect_val_o) begin
        b.cyc = cyc; b.typ = type_rect_o; b.data = rect_o; b.idx = feat_idx_o;
        beat_q.push_back(b);
      end
      if (done_o) done_q.push_back(cyc);
      if (busy_o) begin
        if (busy_cnt == 0) busy_first = cyc;
        busy_cnt++;
      end
    end
  end

  // Parser model: after each rect2 beat, raise wait_i for the next planned
  // number of cycles starting the following cycle.
  initial begin : parser
    int h;
    forever begin
      @(negedge clk_i);
      if (rst_n_i && rect_val_o && type_rect_o && (h_q.size() > 0)) begin
        h = h_q.pop_front();
        @(negedge clk_i);
        if (h > 0) begin
          wait_i = 1'b1;
          repeat (h) @(negedge clk_i);
          wait_i = 1'b0;
        end
      end
    end
  end

  // Run one stage and compare the logged trace with the expected timeline.
  // hmode < 0 draws random wait durations; pulse > 0 fires a stray start.
  task automatic run_stage(input string nm, input logic [AW-1:0] base,
                           input int num, input int hmode, input int pulse);
    int hv[$];
    int f[$];
    int s, t, hi, done_exp, budget, n;
    logic [AW-1:0] ea;
    for (int k = 0; k < num; k++) hv.push_back(hmode < 0 ? int'($urandom_range(0, 15)) : hmode);
    h_q = hv;
    @(negedge clk_i);
    rd_q.delete(); beat_q.delete(); done_q.delete();
    busy_cnt = 0; busy_first = -1;
    s = cyc;
    start_i = 1'b1; base_addr_i = base; feat_num_i = CW'(num);

    // Feature k begins its first read at f[k]; beats follow on f[k]+1, f[k]+2.
    t = s + 1;
    for (int k = 0; k < num; k++) begin
      f.push_back(t);
      hi = (hv[k] > G) ? hv[k] - G : 0;
      t = t + 2 + G + hi + 2;
    end
    done_exp = (num == 0) ? s + 1 : t;

    budget = done_exp - s + 20;
    for (int i = 0; i < budget && done_q.size() == 0; i++) begin
      @(negedge clk_i);
      if (i == 0) begin
        start_i = 1'b0; base_addr_i = AW'($urandom); feat_num_i = CW'($urandom);
      end
      if (pulse > 0 && i == pulse) begin
        start_i = 1'b1; base_addr_i = 12'h555; feat_num_i = 8'd7;
      end
      if (pulse > 0 && i == pulse + 1) start_i = 1'b0;
    end
    repeat (4) @(negedge clk_i);

    n_cmp++;
    if (done_q.size() !== 1) begin
      n_bad++; $display("FAIL %s done_count: got %0d want 1", nm, done_q.size());
    end
    if (done_q.size() > 0) begin
      n_cmp++;
      if (done_q[0] !== done_exp) begin
        n_bad++; $display("FAIL %s done_cycle: got %0d want %0d", nm, done_q[0] - s, done_exp - s);
      end
    end

    n_cmp++;
    if (rd_q.size() !== 2 * num) begin
      n_bad++; $display("FAIL %s read_count: got %0d want %0d", nm, rd_q.size(), 2 * num);
    end
    n = (rd_q.size() < 2 * num) ? rd_q.size() : 2 * num;
    for (int i = 0; i < n; i++) begin
      ea = base + AW'(i);
      n_cmp++;
      if (rd_q[i].addr !== ea) begin
        n_bad++; $display("FAIL %s read_addr[%0d]: got %h want %h", nm, i, rd_q[i].addr, ea);
      end
      n_cmp++;
      if (rd_q[i].cyc !== f[i / 2] + (i % 2)) begin
        n_bad++; $display("FAIL %s read_cycle[%0d]: got %0d want %0d", nm, i, rd_q[i].cyc - s, f[i / 2] + (i % 2) - s);
      end
    end

    n_cmp++;
    if (beat_q.size() !== 2 * num) begin
      n_bad++; $display("FAIL %s beat_count: got %0d want %0d", nm, beat_q.size(), 2 * num);
    end
    n = (beat_q.size() < 2 * num) ? beat_q.size() : 2 * num;
    for (int i = 0; i < n; i++) begin
      ea = base + AW'(i);
      n_cmp++;
      if (beat_q[i].typ !== 1'(i % 2)) begin
        n_bad++; $display("FAIL %s beat_type[%0d]: got %0b want %0b", nm, i, beat_q[i].typ, 1'(i % 2));
      end
      n_cmp++;
      if (beat_q[i].cyc !== f[i / 2] + 1 + (i % 2)) begin
        n_bad++; $display("FAIL %s beat_cycle[%0d]: got %0d want %0d", nm, i, beat_q[i].cyc - s, f[i / 2] + 1 + (i % 2) - s);
      end
      n_cmp++;
      if (beat_q[i].data !== rom_word(ea)) begin
        n_bad++; $display("FAIL %s beat_data[%0d]: got %h want %h", nm, i, beat_q[i].data, rom_word(ea));
      end
      n_cmp++;
      if (beat_q[i].idx !== CW'(i / 2)) begin
        n_bad++; $display("FAIL %s feat_idx[%0d]: got %0d want %0d", nm, i, beat_q[i].idx, i / 2);
      end
    end

    n_cmp++;
    if (busy_cnt !== ((num == 0) ? 0 : done_exp - (s + 1))) begin
      n_bad++; $display("FAIL %s busy_cycles: got %0d want %0d", nm, busy_cnt, (num == 0) ? 0 : done_exp - (s + 1));
    end
    if (num > 0) begin
      n_cmp++;
      if (busy_first !== s + 1) begin
        n_bad++; $display("FAIL %s busy_start: got %0d want %0d", nm, busy_first - s, 1);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if ({feat_rd_o, rect_val_o, type_rect_o, busy_o, done_o} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 00000", {feat_rd_o, rect_val_o, type_rect_o, busy_o, done_o});
    end
    n_cmp++;
    if ({feat_addr_o, feat_idx_o} !== '0) begin
      n_bad++; $display("FAIL reset_addr_idx: got %h/%h want 0/0", feat_addr_o, feat_idx_o);
    end
    rst_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if ({feat_rd_o, rect_val_o, busy_o, done_o} !== 4'b0) begin
      n_bad++; $display("FAIL idle_after_reset: got %b want 0000", {feat_rd_o, rect_val_o, busy_o, done_o});
    end
    n_cmp++;
    if (rect_o !== feat_data_i) begin
      n_bad++; $display("FAIL rect_passthrough: got %h want %h", rect_o, feat_data_i);
    end
  endtask

  task automatic test_single();
    run_stage("single", 12'h010, 1, 12, 0);
  endtask

  task automatic test_three();
    run_stage("three", 12'h100, 3, 12, 0);
  endtask

  task automatic test_zero();
    run_stage("zero", 12'h3A0, 0, 0, 0);
  endtask

  task automatic test_abort();
    logic found;
    int   vals, dones;
    found = 1'b0; vals = 0; dones = 0;
    h_q.delete();
    @(negedge clk_i);
    start_i = 1'b1; base_addr_i = AW'($urandom); feat_num_i = 8'd3;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (rect_val_o && !type_rect_o) found = 1'b1;
    end
    n_cmp++;
    if (found !== 1'b1) begin
      n_bad++; $display("FAIL abort_reach_rect1: got %b want 1", found);
    end
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    n_cmp++;
    if ({busy_o, rect_val_o, feat_rd_o, done_o} !== 4'b0) begin
      n_bad++; $display("FAIL abort_outputs: got %b want 0000", {busy_o, rect_val_o, feat_rd_o, done_o});
    end
    repeat (15) begin
      @(negedge clk_i);
      if (rect_val_o) vals++;
      if (done_o) dones++;
    end
    n_cmp++;
    if (vals !== 0) begin
      n_bad++; $display("FAIL abort_no_rect2: got %0d beats want 0", vals);
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dones);
    end
    run_stage("abort_restart", 12'h200, 2, -1, 0);
  endtask

  task automatic test_wrap();
    run_stage("wrap", 12'hFFE, 2, 6, 5);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++)
      run_stage($sformatf("rand%0d", r), AW'($urandom), int'($urandom_range(1, 4)), -1, 0);
  endtask

  task automatic test_async_reset();
    logic found;
    int   dones, bad_busy, act;
    found = 1'b0; dones = 0; bad_busy = 0; act = 0;
    h_q.delete(); h_q.push_back(60);
    @(negedge clk_i);
    start_i = 1'b1; base_addr_i = AW'($urandom); feat_num_i = 8'd2;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (rect_val_o && type_rect_o) found = 1'b1;
    end
    n_cmp++;
    if (found !== 1'b1) begin
      n_bad++; $display("FAIL areset_reach_rect2: got %b want 1", found);
    end
    // wait_i is held high: the block must sit in WAIT with no done.
    repeat (G + 20) begin
      @(negedge clk_i);
      if (done_o) dones++;
      if (!busy_o) bad_busy++;
    end
    n_cmp++;
    if (dones !== 0 || bad_busy !== 0) begin
      n_bad++; $display("FAIL stuck_wait: got done=%0d idle=%0d want 0/0", dones, bad_busy);
    end
    #2 rst_n_i = 1'b0;
    #1;
    n_cmp++;
    if ({feat_rd_o, rect_val_o, type_rect_o, busy_o, done_o, feat_addr_o, feat_idx_o} !== '0) begin
      n_bad++; $display("FAIL areset_outputs: got %b%b%b%b%b %h %h want all 0",
                        feat_rd_o, rect_val_o, type_rect_o, busy_o, done_o, feat_addr_o, feat_idx_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (10) begin
      @(negedge clk_i);
      if (feat_rd_o || rect_val_o || busy_o || done_o) act++;
    end
    n_cmp++;
    if (act !== 0) begin
      n_bad++; $display("FAIL areset_idle: got %0d active cycles want 0", act);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_zero();
    test_abort();
    test_wrap();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
